// File: rtl/hist_window_readout.sv
// hist_window_readout: per-window delta readout and peak-bin reporter for a free-running 3x3 bin accumulator
//
// Snapshots the accumulator counters once every WINDOW_LEN sample ticks. It streams the nine
// per-bin deltas (mod 2^BIN_W) over a valid/ready port and reports the bin with the largest delta.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   sample_tick  a sample is presented to the accumulator this cycle
//   matrix_i     accumulator counters, [bin][BIN_W-1:0], bin = x*3+y
//   out_data     delta of the current beat
//   out_bin      bin index of the current beat (0..8)
//   out_last     current beat is bin 8
//   out_valid    beat valid
//   out_ready    consumer accepts the beat
//   peak_bin     bin with the largest delta in the last streamed window
//   peak_count   delta of peak_bin
//   peak_valid   one-cycle pulse when peak_bin/peak_count update
//   overrun      sticky: a window closed while the previous one was still capturing/streaming
//
// Build option
//   HIST_READOUT_PEAK_EN  when defined the peak tracker is built; otherwise peak_* are tied to 0.
module hist_window_readout #(
    parameter int WINDOW_LEN = 64,
    parameter int BIN_W      = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic [8:0][BIN_W-1:0] matrix_i,
    output logic [BIN_W-1:0]      out_data,
    output logic [3:0]            out_bin,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            peak_bin,
    output logic [BIN_W-1:0]      peak_count,
    output logic                  peak_valid,
    output logic                  overrun
);
    typedef enum logic [1:0] {COLLECT, CAPTURE, STREAM} state_t;

    state_t                  state, state_nxt;
    logic [8:0]              cnt;
    logic                    pending;
    logic [3:0]              beat;
    logic [8:0][BIN_W-1:0]   prev;
    logic [8:0][BIN_W-1:0]   delta;
    logic                    win_close;
    logic                    hs;
    logic                    last_hs;

    assign win_close = sample_tick && (cnt == 9'(WINDOW_LEN - 1));
    assign hs        = out_valid && out_ready;
    assign last_hs   = hs && out_last;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    // A close that lands on the last handshake is treated like a pending one so it is not lost.
    always_comb begin
        state_nxt = state == COLLECT ? (win_close ? CAPTURE : COLLECT) :
                    state == CAPTURE ? STREAM :
                    state == STREAM  ? (last_hs ? ((pending || win_close) ? CAPTURE : COLLECT) : STREAM) :
                    COLLECT;
        out_valid = state == STREAM;
        out_bin   = beat;
        out_data  = delta[beat];
        out_last  = beat == 4'd8;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            beat    <= '0;
            prev    <= '0;
            delta   <= '0;
        end else begin
            if (sample_tick)
                cnt <= win_close ? '0 : cnt + 9'd1;
            if (win_close && state != COLLECT)
                overrun <= 1'b1;
            if (last_hs)
                pending <= 1'b0;
            else if (win_close && state != COLLECT)
                pending <= 1'b1;
            if (state == CAPTURE) begin
                prev <= matrix_i;
                beat <= '0;
                for (int i = 0; i < 9; i++)
                    delta[i] <= matrix_i[i] - prev[i];
            end else if (hs) begin
                beat <= beat + 4'd1;
            end
        end
    end

`ifdef HIST_READOUT_PEAK_EN
    logic [3:0]       run_bin;
    logic [BIN_W-1:0] run_cnt;
    logic             upd;

    // Strictly-greater update keeps the lowest bin on ties.
    assign upd = hs && (out_data > run_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_bin    <= '0;
            run_cnt    <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= last_hs;
            if (state == CAPTURE) begin
                run_bin <= '0;
                run_cnt <= '0;
            end else if (upd) begin
                run_bin <= beat;
                run_cnt <= out_data;
            end
            if (last_hs) begin
                peak_bin   <= upd ? beat : run_bin;
                peak_count <= upd ? out_data : run_cnt;
            end
        end
    end
`else
    assign peak_bin   = '0;
    assign peak_count = '0;
    assign peak_valid = 1'b0;
`endif
endmodule
